frame_readout: RTL and testbench

Parametrised frame read-out sequencer between the frame buffer's read port and the processor-visible pixel registers. While the processor asserts `freeze`, it walks the stored frame one BRAM word at a time. Each word holds `PIX_PER_WORD` RGB444 pixels, and the block expands every pixel to RGB888 and presents the result on a registered output with a valid flag. The block advances one word per `read_enable` pulse, wraps at end of frame, and reports frame completion and protocol overruns.

---
 rtl/frame_readout_pkg.sv | 18 +
 rtl/rgb444_expand.sv | 17 +
 rtl/frame_readout.sv | 137 +++++++++++++
 tb/tb_frame_readout.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_readout_pkg.sv
// Shared constants, sequencer states and RGB444 channel expansion for frame_readout.
package frame_readout_pkg;

    localparam int PIX_IN_W  = 12;
    localparam int PIX_OUT_W = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2
    } state_e;

    // mode 1 replicates the nibble so full scale maps to full scale; mode 0 zero-fills
    function automatic logic [7:0] expand_chan(input logic [3:0] c, input logic mode);
        return mode ? {c, c} : {c, 4'h0};
    endfunction

endpackage

// File: rtl/rgb444_expand.sv
// Combinational RGB444 -> RGB888 expansion of one pixel; zero latency, no flow control.
module rgb444_expand
    import frame_readout_pkg::*;
#(
    parameter int EXPAND_MODE = 1
) (
    input  logic [PIX_IN_W-1:0]  pix_i,
    output logic [PIX_OUT_W-1:0] pix_o
);

    localparam logic MODE = (EXPAND_MODE != 0);

    assign pix_o = {expand_chan(pix_i[11:8], MODE),
                    expand_chan(pix_i[7:4],  MODE),
                    expand_chan(pix_i[3:0],  MODE)};

endmodule

// File: rtl/frame_readout.sv
// Frame read-out sequencer: walks the frame one BRAM word per read_enable while frozen.
// Word valid BRAM_LATENCY+2 cycles after an accept; read_enable outside READY never advances.
module frame_readout
    import frame_readout_pkg::*;
#(
    parameter int PIX_PER_WORD = 4,
    parameter int FRAME_WORDS  = 76800,
    parameter int ADDR_W       = 17,
    parameter int BRAM_LATENCY = 2,
    parameter int EXPAND_MODE  = 1
) (
    input  logic                              clk50,
    input  logic                              rst,
    input  logic                              freeze,
    input  logic                              read_enable,
    output logic [ADDR_W-1:0]                 bram_addr,
    input  logic [PIX_IN_W*PIX_PER_WORD-1:0]  bram_dout,
    output logic [PIX_OUT_W*PIX_PER_WORD-1:0] pix_data,
    output logic                              pix_valid,
    output logic [ADDR_W-1:0]                 word_idx,
    output logic                              frame_done,
    output logic [7:0]                        frame_count,
    output logic                              overrun
);

    localparam int               OUT_W     = PIX_OUT_W * PIX_PER_WORD;
    localparam logic [2:0]       LAT       = 3'(BRAM_LATENCY);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    state_e             state_q, state_d;
    logic [2:0]         wait_q, wait_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [OUT_W-1:0]   pix_q, pix_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic [7:0]         fcnt_q, fcnt_d;
    logic               ovr_q, ovr_d;
    logic [OUT_W-1:0]   expanded;

    for (genvar p = 0; p < PIX_PER_WORD; p++) begin : g_pix
        rgb444_expand #(
            .EXPAND_MODE(EXPAND_MODE)
        ) u_expand (
            .pix_i(bram_dout[PIX_IN_W*(PIX_PER_WORD-p)-1 -: PIX_IN_W]),
            .pix_o(expanded[PIX_OUT_W*(PIX_PER_WORD-p)-1 -: PIX_OUT_W])
        );
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        pix_d   = pix_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        fcnt_d  = fcnt_q;
        ovr_d   = ovr_q;
        // Losing freeze abandons the frame outright, even mid-accept
        if (!freeze) begin
            state_d = IDLE;
            addr_d  = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    wait_d  = LAT;
                end
                FETCH: begin
                    if (read_enable) begin
                        ovr_d = 1'b1;
                    end
                    if (wait_q == 3'd0) begin
                        state_d = READY;
                        valid_d = 1'b1;
                        pix_d   = expanded;
                        idx_d   = addr_q;
                    end else begin
                        wait_d = wait_q - 3'd1;
                    end
                end
                READY: begin
                    if (read_enable) begin
                        state_d = FETCH;
                        wait_d  = LAT;
                        valid_d = 1'b0;
                        if (addr_q == LAST_ADDR) begin
                            addr_d = '0;
                            done_d = 1'b1;
                            fcnt_d = fcnt_q + 8'd1;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            state_q <= IDLE;
            wait_q  <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            pix_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            fcnt_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            pix_q   <= pix_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            fcnt_q  <= fcnt_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bram_addr   = addr_q;
    assign pix_data    = pix_q;
    assign pix_valid   = valid_q;
    assign word_idx    = idx_q;
    assign frame_done  = done_q;
    assign frame_count = fcnt_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_frame_readout.sv
// Bench for frame_readout: expansion table, cadence/overrun/freeze corner cases, randomized 256-frame run.
module tb_frame_readout;

    localparam int PPW = 4;
    localparam int FW  = 8;
    localparam int AW  = 3;
    localparam int LAT = 2;
    localparam int DW  = 12 * PPW;
    localparam int OW  = 24 * PPW;

    logic          clk50 = 1'b0;
    logic          rst, freeze, read_enable;
    logic [AW-1:0] bram_addr, bram_addr0;
    logic [DW-1:0] bram_dout, bram_dout0;
    logic [OW-1:0] pix_data, pix_data0;
    logic          pix_valid, pix_valid0;
    logic [AW-1:0] word_idx, word_idx0;
    logic          frame_done, frame_done0;
    logic [7:0]    frame_count, frame_count0;
    logic          overrun, overrun0;

    typedef struct {
        logic [DW-1:0] word;
        logic [OW-1:0] exp1;
        logic [OW-1:0] exp0;
    } vec_t;

    vec_t          tbl [FW];
    logic [DW-1:0] mem [FW];
    logic [AW-1:0] pipe1 [LAT];
    logic [AW-1:0] pipe0 [LAT];
    int            n_chk = 0;
    int            n_err = 0;
    int            done_cnt = 0;

    always #10 clk50 = ~clk50;

    frame_readout #(.PIX_PER_WORD(PPW), .FRAME_WORDS(FW), .ADDR_W(AW),
                    .BRAM_LATENCY(LAT), .EXPAND_MODE(1)) u_dut (
        .clk50(clk50), .rst(rst), .freeze(freeze), .read_enable(read_enable),
        .bram_addr(bram_addr), .bram_dout(bram_dout), .pix_data(pix_data),
        .pix_valid(pix_valid), .word_idx(word_idx), .frame_done(frame_done),
        .frame_count(frame_count), .overrun(overrun)
    );

    frame_readout #(.PIX_PER_WORD(PPW), .FRAME_WORDS(FW), .ADDR_W(AW),
                    .BRAM_LATENCY(LAT), .EXPAND_MODE(0)) u_dut0 (
        .clk50(clk50), .rst(rst), .freeze(freeze), .read_enable(read_enable),
        .bram_addr(bram_addr0), .bram_dout(bram_dout0), .pix_data(pix_data0),
        .pix_valid(pix_valid0), .word_idx(word_idx0), .frame_done(frame_done0),
        .frame_count(frame_count0), .overrun(overrun0)
    );

    // BRAM model: data for an address appears LAT cycles after it is presented
    always @(posedge clk50) begin
        pipe1[0] <= bram_addr;
        pipe0[0] <= bram_addr0;
        for (int i = 1; i < LAT; i++) begin
            pipe1[i] <= pipe1[i-1];
            pipe0[i] <= pipe0[i-1];
        end
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    end
    assign bram_dout  = mem[pipe1[LAT-1]];
    assign bram_dout0 = mem[pipe0[LAT-1]];

    // Each nibble scaled arithmetically: x17 fills the byte, x16 leaves the low nibble zero
    function automatic logic [OW-1:0] ref_expand(input logic [DW-1:0] w, input bit mode);
        logic [OW-1:0] r;
        logic [OW-1:0] t;
        r = '0;
        for (int p = 0; p < PPW; p++) begin
            for (int c = 0; c < 3; c++) begin
                int nib;
                int v;
                nib = int'((w >> (DW - 4 - 12*p - 4*c)) & DW'(15));
                v   = mode ? nib * 17 : nib * 16;
                t   = OW'(v);
                r   = r | (t << (OW - 8 - 24*p - 8*c));
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (pix_valid !== 1'b1 && n < 40) begin
            @(negedge clk50);
            n++;
        end
        if (pix_valid !== 1'b1) check("valid_timeout", pix_valid, 1);
    endtask

    task automatic consume;
        int n;
        read_enable = 1'b1;
        @(negedge clk50);
        read_enable = 1'b0;
        wait_valid(n);
    endtask

    initial begin
        int          n;
        int          d0;
        logic [AW-1:0] exp_addr;
        logic [7:0]  exp_fc;
        logic        exp_ovr;
        int          exp_done;
        bit          spur;
        bit          wrapped;

        tbl[0] = '{48'hF00_0F0_00F_ABC, 96'hFF0000_00FF00_0000FF_AABBCC, 96'hF00000_00F000_0000F0_A0B0C0};
        tbl[1] = '{48'h000_000_000_000, 96'h000000_000000_000000_000000, 96'h000000_000000_000000_000000};
        tbl[2] = '{48'hFFF_FFF_FFF_FFF, 96'hFFFFFF_FFFFFF_FFFFFF_FFFFFF, 96'hF0F0F0_F0F0F0_F0F0F0_F0F0F0};
        tbl[3] = '{48'h123_456_789_DEF, 96'h112233_445566_778899_DDEEFF, 96'h102030_405060_708090_D0E0F0};
        for (int i = 4; i < FW; i++) begin
            tbl[i].word = DW'({$urandom(), $urandom()});
            tbl[i].exp1 = ref_expand(tbl[i].word, 1'b1);
            tbl[i].exp0 = ref_expand(tbl[i].word, 1'b0);
        end
        for (int i = 0; i < FW; i++) mem[i] = tbl[i].word;

        // Reset with freeze already held high
        rst = 1'b1; freeze = 1'b1; read_enable = 1'b0;
        repeat (3) @(negedge clk50);
        check("rst_addr",  bram_addr,   0);
        check("rst_pix",   pix_data,    0);
        check("rst_valid", pix_valid,   0);
        check("rst_idx",   word_idx,    0);
        check("rst_done",  frame_done,  0);
        check("rst_fc",    frame_count, 0);
        check("rst_ovr",   overrun,     0);
        rst = 1'b0;
        wait_valid(n);
        check("first_lat", n, LAT + 2);

        // One full frame at maximum cadence, checking the expansion table word by word
        for (int i = 0; i < FW; i++) begin
            int m;
            check("tbl_idx",  word_idx,  i);
            check("tbl_addr", bram_addr, i);
            check("tbl_m1",   pix_data,  tbl[i].exp1);
            check("tbl_m0",   pix_data0, tbl[i].exp0);
            read_enable = 1'b1;
            @(negedge clk50);
            read_enable = 1'b0;
            check("adv_addr",  bram_addr,  (i + 1) % FW);
            check("adv_done",  frame_done, (i == FW - 1));
            check("adv_valid", pix_valid,  0);
            wait_valid(m);
            check("cadence", m + 1, LAT + 2);
        end
        check("frame_done_cnt", done_cnt,    1);
        check("frame_cnt_1",    frame_count, 1);
        check("wrap_idx",       word_idx,    0);

        // Second read_enable while fetching: overrun, no extra advance
        check("ovr_init", overrun, 0);
        read_enable = 1'b1;
        @(negedge clk50);
        @(negedge clk50);
        read_enable = 1'b0;
        check("ovr_set",  overrun,   1);
        check("ovr_addr", bram_addr, 1);
        wait_valid(n);
        check("ovr_idx",  word_idx,  1);
        check("ovr_sticky", overrun, 1);

        // Freeze dropped at word 5
        repeat (4) consume();
        check("w5_idx", word_idx, 5);
        freeze = 1'b0;
        @(negedge clk50);
        check("drop_addr",  bram_addr,   0);
        check("drop_valid", pix_valid,   0);
        check("drop_ovr",   overrun,     0);
        check("drop_fc",    frame_count, 1);
        check("drop_done",  frame_done,  0);
        freeze = 1'b1;
        wait_valid(n);
        check("refreeze_lat", n, LAT + 2);
        check("refreeze_idx", word_idx, 0);
        check("refreeze_pix", pix_data, ref_expand(mem[0], 1'b1));
        check("drop_done_cnt", done_cnt, 1);

        // read_enable on the last word coincident with freeze falling
        repeat (FW - 1) consume();
        check("last_idx", word_idx, FW - 1);
        d0 = done_cnt;
        read_enable = 1'b1; freeze = 1'b0;
        @(negedge clk50);
        read_enable = 1'b0; freeze = 1'b1;
        check("coin_addr",  bram_addr,   0);
        check("coin_done",  frame_done,  0);
        check("coin_valid", pix_valid,   0);
        check("coin_fc",    frame_count, 1);
        wait_valid(n);
        check("coin_idx",      word_idx, 0);
        check("coin_done_cnt", done_cnt, d0);

        // Randomized consumer until frame_count wraps past 255
        exp_addr = '0; exp_fc = 8'd1; exp_ovr = 1'b0; exp_done = done_cnt; wrapped = 1'b0;
        for (int it = 0; it < 20000 && !wrapped; it++) begin
            wait_valid(n);
            check("rnd_idx", word_idx, exp_addr);
            check("rnd_pix", pix_data, ref_expand(mem[exp_addr], 1'b1));
            repeat ($urandom_range(0, 2)) @(negedge clk50);
            if ($urandom_range(0, 63) == 0) begin
                freeze = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk50);
                freeze = 1'b1;
                exp_addr = '0;
                exp_ovr  = 1'b0;
                check("rnd_drop_ovr", overrun, exp_ovr);
            end else begin
                spur = ($urandom_range(0, 7) == 0);
                read_enable = 1'b1;
                @(negedge clk50);
                read_enable = spur;
                @(negedge clk50);
                read_enable = 1'b0;
                if (spur) exp_ovr = 1'b1;
                if (exp_addr == AW'(FW - 1)) begin
                    exp_addr = '0;
                    exp_fc   = exp_fc + 8'd1;
                    exp_done = exp_done + 1;
                end else begin
                    exp_addr = exp_addr + 1'b1;
                end
                check("rnd_ovr",  overrun,     exp_ovr);
                check("rnd_fc",   frame_count, exp_fc);
                check("rnd_done", done_cnt,    exp_done);
            end
            if (exp_fc == 8'd0) wrapped = 1'b1;
        end
        check("wrap_reached", wrapped, 1);
        check("fc_wrap", frame_count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
